// File: rtl/bist_pkg.sv
// Shared types for the BIST controller: FSM states, golden vector layout.
// Build option: BIST_STOP_ON_ERROR_EN ends a run at the first mismatch.
package bist_pkg;

  localparam int NUM_VEC_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    CHECK,
    DONE
  } state_t;

  typedef struct packed {
    logic a;
    logic b;
    logic c;
    logic y_exp;
  } vec_t;

  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bist_controller_if.sv
// Stimulus/response and status bundle between the BIST controller
// and the logic around it (function under test, status readers).
interface bist_controller_if #(
  parameter int NUM_VEC = bist_pkg::NUM_VEC_DEF
);
  localparam int EW = $clog2(NUM_VEC + 1);
  localparam int FW = bist_pkg::idx_w(NUM_VEC);

  logic          start;
  logic          y;
  logic          a;
  logic          b;
  logic          c;
  logic          busy;
  logic          done;
  logic          pass;
  logic [EW-1:0] err_cnt;
  logic [FW-1:0] first_fail;

  modport master (
    input  start, y,
    output a, b, c,
    output busy, done, pass,
    output err_cnt, first_fail
  );

  modport slave (
    output start, y,
    input  a, b, c,
    input  busy, done, pass,
    input  err_cnt, first_fail
  );

endinterface

// File: rtl/bist_vec_rom.sv
// Golden vector table: {a,b,c} is the index, y is high for 0, 4 and 5.
// Purely combinational lookup.
module bist_vec_rom
  import bist_pkg::*;
(
  input  logic [2:0] idx,
  output vec_t       vec
);

  always_comb begin
    vec.a     = idx[2];
    vec.b     = idx[1];
    vec.c     = idx[0];
    vec.y_exp = 1'b0;
    unique case (1'b1)
      idx == 3'd0,
      idx == 3'd4,
      idx == 3'd5: vec.y_exp = 1'b1;
      default:     vec.y_exp = 1'b0;
    endcase
  end

endmodule

// File: rtl/bist_controller.sv
// Walks the golden table through an external function and counts misses.
// Build option: BIST_STOP_ON_ERROR_EN ends the run at the first mismatch.
module bist_controller
  import bist_pkg::*;
#(
  parameter int NUM_VEC       = NUM_VEC_DEF,
  parameter int SETTLE_CYCLES = 1
) (
  input logic         clk,
  input logic         reset,
  bist_controller_if.master bus
);

  localparam int EW = $clog2(NUM_VEC + 1);
  localparam int FW = idx_w(NUM_VEC);

  localparam logic [FW-1:0] LAST_IDX =
    FW'(NUM_VEC - 1);
  localparam logic [3:0] SET_LAST =
    4'(SETTLE_CYCLES - 1);

  state_t        state;
  logic [FW-1:0] vec_idx;
  logic [3:0]    settle;
  vec_t          cur;
  logic          busy;
  logic          done;
  logic          pass;
  logic [EW-1:0] err_cnt;
  logic [FW-1:0] first_fail;

  logic [2:0]    rom_idx;
  vec_t          rom_vec;
  logic          miss;
  logic          last;
  logic          stop;
  logic [EW-1:0] err_nxt;

  // ROM is addressed with the vector that the next load will need.
  always_comb begin
    rom_idx = 3'd0;
    if (state == CHECK)
      rom_idx = 3'(vec_idx + 1'b1);
  end

  bist_vec_rom u_rom (
    .idx (rom_idx),
    .vec (rom_vec)
  );

  assign miss    = bus.y != cur.y_exp;
  assign last    = vec_idx == LAST_IDX;
  assign err_nxt = err_cnt + EW'(miss);

`ifdef BIST_STOP_ON_ERROR_EN
  assign stop = miss;
`else
  assign stop = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      vec_idx    <= '0;
      settle     <= '0;
      cur        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      first_fail <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state      <= APPLY;
            vec_idx    <= '0;
            settle     <= '0;
            err_cnt    <= '0;
            first_fail <= '0;
            cur        <= rom_vec;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
          end
        end
        APPLY: begin
          if (settle == SET_LAST) begin
            settle <= '0;
            state  <= CHECK;
          end else begin
            settle <= settle + 4'd1;
          end
        end
        CHECK: begin
          err_cnt <= err_nxt;
          if (miss && err_cnt == '0)
            first_fail <= vec_idx;
          if (last || stop) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= err_nxt == '0;
          end else begin
            state   <= APPLY;
            vec_idx <= vec_idx + 1'b1;
            cur     <= rom_vec;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.a          = cur.a;
  assign bus.b          = cur.b;
  assign bus.c          = cur.c;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.pass       = pass;
  assign bus.err_cnt    = err_cnt;
  assign bus.first_fail = first_fail;

endmodule

// File: tb/tb_bist_controller.sv
// Bench for bist_controller: settle 1 and settle 3 instances
// checked each cycle against a table-level run model.
module tb_bist_controller;
  import bist_pkg::*;

  localparam int N = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  bist_controller_if #(.NUM_VEC(N)) bus1 ();
  bist_controller_if #(.NUM_VEC(N)) bus3 ();

  bist_controller #(
    .NUM_VEC(N),
    .SETTLE_CYCLES(1)
  ) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.master)
  );

  bist_controller #(
    .NUM_VEC(N),
    .SETTLE_CYCLES(3)
  ) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3.master)
  );

  int checks = 0;
  int errors = 0;

  logic st [2];
  int   md [2];

  // Function under test: 0 = correct, 1 = stuck 0, 2 = stuck 1.
  function automatic logic fut(
    int m, logic a, logic b, logic c);
    if (m == 1) return 1'b0;
    if (m == 2) return 1'b1;
    return ~b & (a | ~c);
  endfunction

  assign bus1.start = st[0];
  assign bus3.start = st[1];
  assign bus1.y = fut(md[0], bus1.a, bus1.b, bus1.c);
  assign bus3.y = fut(md[1], bus3.a, bus3.b, bus3.c);

  logic [2:0] aabc  [2];
  logic       abusy [2];
  logic       adone [2];
  logic       apass [2];
  logic [3:0] aerr  [2];
  logic [2:0] aff   [2];

  assign aabc[0]  = {bus1.a, bus1.b, bus1.c};
  assign aabc[1]  = {bus3.a, bus3.b, bus3.c};
  assign abusy[0] = bus1.busy;
  assign abusy[1] = bus3.busy;
  assign adone[0] = bus1.done;
  assign adone[1] = bus3.done;
  assign apass[0] = bus1.pass;
  assign apass[1] = bus3.pass;
  assign aerr[0]  = bus1.err_cnt;
  assign aerr[1]  = bus3.err_cnt;
  assign aff[0]   = bus1.first_fail;
  assign aff[1]   = bus3.first_fail;

  task automatic chk(
    input string nm, input int d,
    input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d got %0d want %0d t=%0t",
               nm, d, act, exp, $time);
    end
  endtask

  function automatic logic gold(int i);
    return (i == 0) || (i == 4) || (i == 5);
  endfunction

  function automatic logic ymod(int m, int i);
    if (m == 1) return 1'b0;
    if (m == 2) return 1'b1;
    return gold(i);
  endfunction

  // Outputs expected kk edges after the start edge of a run.
  function automatic void model(
    input int s, input int m,
    input bit a, input int kk,
    output int abc, output int busy,
    output int done, output int pass,
    output int errs, output int first);
    int nrun;
    int c;
    int vec;
    nrun = N;
`ifdef BIST_STOP_ON_ERROR_EN
    for (int j = N - 1; j >= 0; j--)
      if (ymod(m, j) != gold(j)) nrun = j + 1;
`endif
    abc = 0; busy = 0; done = 0;
    pass = 0; errs = 0; first = 0;
    if (!a) return;
    if (kk < (s + 1) * nrun) begin
      busy = 1;
      c = kk / (s + 1);
      vec = c;
    end else begin
      done = 1;
      c = nrun;
      vec = nrun - 1;
    end
    for (int j = c - 1; j >= 0; j--)
      if (ymod(m, j) != gold(j)) begin
        errs++;
        first = j;
      end
    pass = (done != 0 && errs == 0) ? 1 : 0;
    abc = vec;
  endfunction

  bit act  [2];
  int k    [2];
  int mrun [2];

  always @(posedge clk or negedge reset) begin : mdl
    int e_abc, e_b, e_d, e_p, e_e, e_f;
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        act[d] <= 1'b0;
        k[d]   <= 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        model(d ? 3 : 1, mrun[d], act[d], k[d],
              e_abc, e_b, e_d, e_p, e_e, e_f);
        if (e_b == 0 && st[d]) begin
          act[d]  <= 1'b1;
          k[d]    <= 0;
          mrun[d] <= md[d];
        end else if (act[d] && k[d] < 100000) begin
          k[d] <= k[d] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin : cmp
    int e_abc, e_b, e_d, e_p, e_e, e_f;
    for (int d = 0; d < 2; d++) begin
      model(d ? 3 : 1, mrun[d], act[d], k[d],
            e_abc, e_b, e_d, e_p, e_e, e_f);
      chk("m_abc", d, int'(aabc[d]), e_abc);
      chk("m_busy", d, int'(abusy[d]), e_b);
      chk("m_done", d, int'(adone[d]), e_d);
      chk("m_pass", d, int'(apass[d]), e_p);
      chk("m_err", d, int'(aerr[d]), e_e);
      if (e_e != 0)
        chk("m_ff", d, int'(aff[d]), e_f);
    end
  end

  task automatic pulse(input int d);
    st[d] = 1'b1;
    @(negedge clk);
    #1 st[d] = 1'b0;
  endtask

  task automatic run_lat(
    input int d, input int m, input int lat,
    input int e, input int f, input int p);
    md[d] = m;
    pulse(d);
    repeat (lat - 1) @(negedge clk);
    chk("pre_done", d, int'(adone[d]), 0);
    @(negedge clk);
    chk("done", d, int'(adone[d]), 1);
    chk("err_cnt", d, int'(aerr[d]), e);
    if (e != 0)
      chk("first_fail", d, int'(aff[d]), f);
    chk("pass", d, int'(apass[d]), p);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    st[0] = 1'b0;
    st[1] = 1'b0;
    md[0] = 0;
    md[1] = 0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy", d, int'(abusy[d]), 0);
      chk("rst_done", d, int'(adone[d]), 0);
      chk("rst_err", d, int'(aerr[d]), 0);
      chk("rst_abc", d, int'(aabc[d]), 0);
    end
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;

    run_lat(0, 0, 16, 0, 0, 1);
`ifdef BIST_STOP_ON_ERROR_EN
    run_lat(0, 1, 2, 1, 0, 0);
    run_lat(0, 2, 4, 1, 1, 0);
`else
    run_lat(0, 1, 16, 3, 0, 0);
    run_lat(0, 2, 16, 5, 1, 0);
`endif

    // Reset mid-run, between clock edges.
    md[0] = 1;
    pulse(0);
    repeat (4) @(negedge clk);
    @(posedge clk);
    chk("pre_rst_err", 0, int'(aerr[0]), 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", 0, int'(abusy[0]), 0);
    chk("arst_done", 0, int'(adone[0]), 0);
    chk("arst_pass", 0, int'(apass[0]), 0);
    chk("arst_err", 0, int'(aerr[0]), 0);
    chk("arst_ff", 0, int'(aff[0]), 0);
    chk("arst_abc", 0, int'(aabc[0]), 0);
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    #1;
    run_lat(0, 0, 16, 0, 0, 1);

    // Start held high on both instances.
    md[0] = 0;
    md[1] = 0;
    st[0] = 1'b1;
    st[1] = 1'b1;
    @(negedge clk);
    repeat (15) @(negedge clk);
    chk("hold_pre", 0, int'(adone[0]), 0);
    @(negedge clk);
    chk("hold_done", 0, int'(adone[0]), 1);
    @(negedge clk);
    chk("restart_busy", 0, int'(abusy[0]), 1);
    chk("restart_done", 0, int'(adone[0]), 0);
    repeat (14) @(negedge clk);
    chk("s3_pre", 1, int'(adone[1]), 0);
    @(negedge clk);
    chk("s3_done", 1, int'(adone[1]), 1);
    chk("s3_pass", 1, int'(apass[1]), 1);
    #1;
    st[0] = 1'b0;
    st[1] = 1'b0;
    repeat (40) @(negedge clk);
    chk("end_done", 0, int'(adone[0]), 1);
    chk("end_done", 1, int'(adone[1]), 1);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bist_controller.md
BIST_CONTROLLER -- requirements
Module: bist_controller

Interface
REQ-001 Parameter NUM_VEC, default 8: number of test vectors in the golden table.
REQ-002 Parameter SETTLE_CYCLES, default 1, range 1..15: cycles each vector is held before the output is sampled.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  run request; sampled only in IDLE or DONE.
REQ-006 y  input  1  output of the combinational function under test.
REQ-007 a, b, c  output  1 each  registered stimulus to the function under test.
REQ-008 busy  output  1  high in APPLY or CHECK.
REQ-009 done  output  1  high in DONE.
REQ-010 pass  output  1  high in DONE when err_cnt == 0.
REQ-011 err_cnt  output  $clog2(NUM_VEC+1)  number of mismatching vectors in the current or last run.
REQ-012 first_fail  output  $clog2(NUM_VEC)  index of the first mismatching vector; meaningful only when err_cnt != 0.

Function
REQ-013 State machine SHALL have exactly four states: IDLE, APPLY, CHECK, DONE.
REQ-014 Golden table entry i SHALL be {a,b,c,y_exp}, with a,b,c = i[2:0] and y_exp = 1 only for i = 0, 4, 5; entries 0..7 only.
REQ-015 IDLE or DONE with start=1 at an edge -> APPLY; vec_idx=0, err_cnt=0, first_fail=0, {a,b,c}=table[0].
REQ-016 APPLY SHALL hold {a,b,c} constant for SETTLE_CYCLES cycles using a settle counter, then -> CHECK.
REQ-017 CHECK, single cycle: compare y with table[vec_idx].y_exp; on mismatch increment err_cnt; if err_cnt was 0, capture first_fail = vec_idx.
REQ-018 CHECK with vec_idx < NUM_VEC-1 -> APPLY; increment vec_idx; load the next vector into {a,b,c} on the same edge.
REQ-019 CHECK with vec_idx == NUM_VEC-1 -> DONE; no wrap of vec_idx.
REQ-020 Latency: done SHALL rise exactly (SETTLE_CYCLES+1)*NUM_VEC cycles after the edge that samples start.
REQ-021 start while busy SHALL be ignored; no restart, no counter change.
REQ-022 DONE SHALL hold done, pass, err_cnt and first_fail until a new start or reset; start in DONE restarts per REQ-015.
REQ-023 err_cnt SHALL NOT saturate or wrap; its width covers the maximum count of NUM_VEC.
REQ-024 {a,b,c} SHALL keep their last value in DONE.

Reset
REQ-025 reset low SHALL immediately force IDLE, vec_idx=0, settle counter=0, a=b=c=0, busy=0, done=0, pass=0, err_cnt=0, first_fail=0, including mid-run.
REQ-026 After reset deasserts, the block SHALL wait in IDLE for start.

Configuration
REQ-027 With BIST_STOP_ON_ERROR_EN defined: the first mismatch in CHECK SHALL go directly to DONE with err_cnt=1 and first_fail set; remaining vectors are not applied.
REQ-028 Without BIST_STOP_ON_ERROR_EN: every vector SHALL be applied regardless of mismatches.

Structure
REQ-029 Package bist_pkg SHALL hold the state enum, the vector struct {a,b,c,y_exp}, and the NUM_VEC default.
REQ-030 The golden table SHALL be a separate sub-module, bist_vec_rom: combinational, index in, vector struct out.
REQ-031 bist_controller SHALL NOT instantiate the function under test; a and y connect at top level.

Verification
REQ-032 Correct function, SETTLE_CYCLES=1, one start pulse -> done 16 cycles later, err_cnt=0, pass=1.
REQ-033 y tied to 0 -> err_cnt=3, first_fail=0, pass=0; y tied to 1 -> err_cnt=5, first_fail=1.
REQ-034 BIST_STOP_ON_ERROR_EN, y tied to 0 -> done 2 cycles after start, err_cnt=1, first_fail=0.
REQ-035 reset pulsed low at cycle 5 of a run -> all outputs 0 asynchronously; a new start then gives a full 16-cycle run.
REQ-036 start held high through a whole run -> no restart while busy; immediate restart from DONE; SETTLE_CYCLES=3 run -> done after 32 cycles.
